// File: rtl/hwpe_kernel_adapter_mc.sv
// hwpe_kernel_adapter_mc: gates and counts N_IN/N_OUT stream handshakes against per-job limits.
module hwpe_kernel_adapter_mc #(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 1,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [N_IN*CNT_W-1:0]   in_max_i,
    input  logic [N_OUT*CNT_W-1:0]  out_max_i,
    input  logic [N_IN-1:0]         in_valid_i,
    output logic [N_IN-1:0]         in_ready_o,
    input  logic [N_IN*DATA_W-1:0]  in_data_i,
    output logic [N_IN-1:0]         k_in_valid_o,
    input  logic [N_IN-1:0]         k_in_ready_i,
    output logic [N_IN*DATA_W-1:0]  k_in_data_o,
    input  logic [N_OUT-1:0]        k_out_valid_i,
    output logic [N_OUT-1:0]        k_out_ready_o,
    input  logic [N_OUT*DATA_W-1:0] k_out_data_i,
    output logic [N_OUT-1:0]        out_valid_o,
    input  logic [N_OUT-1:0]        out_ready_i,
    output logic [N_OUT*DATA_W-1:0] out_data_o,
    output logic                    ready_o,
    output logic                    done_o,
    output logic                    idle_o,
    output logic [N_IN*CNT_W-1:0]   in_cnt_o,
    output logic [N_OUT*CNT_W-1:0]  out_cnt_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    state_e state_q, state_d;
    logic [N_IN-1:0][CNT_W-1:0]  in_lim_q, in_cnt_q;
    logic [N_OUT-1:0][CNT_W-1:0] out_lim_q, out_cnt_q;
    logic [N_IN-1:0]             in_open, in_full;
    logic [N_OUT-1:0]            out_open, out_full;
    logic                        run;

    assign run = state_q == RUN;

    for (genvar i = 0; i < N_IN; i++) begin : g_in
        assign in_full[i] = in_cnt_q[i] == in_lim_q[i];
        assign in_open[i] = run && in_cnt_q[i] < in_lim_q[i];
    end
    for (genvar i = 0; i < N_OUT; i++) begin : g_out
        assign out_full[i] = out_cnt_q[i] == out_lim_q[i];
        assign out_open[i] = run && out_cnt_q[i] < out_lim_q[i];
    end

    assign k_in_valid_o  = in_valid_i & in_open;
    assign in_ready_o    = k_in_ready_i & in_open;
    assign k_in_data_o   = in_data_i;
    assign out_valid_o   = k_out_valid_i & out_open;
    assign k_out_ready_o = out_ready_i & out_open;
    assign out_data_o    = k_out_data_i;

    assign ready_o   = run && &in_full;
    assign done_o    = state_q == DONE;
    assign idle_o    = state_q == IDLE;
    assign in_cnt_o  = in_cnt_q;
    assign out_cnt_o = out_cnt_q;

    // completion is judged on registered counters, so DONE lands two cycles after the last beat
    always_comb begin
        state_d = state_q;
        state_d = (state_q == IDLE && start_i) ? RUN :
                  (run && &out_full)           ? DONE :
                  (state_q == DONE)            ? IDLE : state_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q   <= IDLE;
            in_lim_q  <= '0;
            out_lim_q <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start_i) begin
                in_lim_q  <= in_max_i;
                out_lim_q <= out_max_i;
                in_cnt_q  <= '0;
                out_cnt_q <= '0;
            end else begin
                for (int c = 0; c < N_IN; c++)
                    if (k_in_valid_o[c] && in_ready_o[c]) in_cnt_q[c] <= in_cnt_q[c] + CNT_W'(1);
                for (int c = 0; c < N_OUT; c++)
                    if (out_valid_o[c] && k_out_ready_o[c]) out_cnt_q[c] <= out_cnt_q[c] + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_hwpe_kernel_adapter_mc.sv
// tb_hwpe_kernel_adapter_mc: directed self-checking bench for hwpe_kernel_adapter_mc.
module tb_hwpe_kernel_adapter_mc;
    logic        clk_i = 0, rst_i, clear_i, start_i;
    logic [31:0] in_max_i;
    logic [15:0] out_max_i;
    logic [1:0]  in_valid_i, in_ready_o, k_in_valid_o, k_in_ready_i;
    logic [63:0] in_data_i, k_in_data_o;
    logic        k_out_valid_i, k_out_ready_o, out_valid_o, out_ready_i;
    logic [31:0] k_out_data_i, out_data_o;
    logic        ready_o, done_o, idle_o;
    logic [31:0] in_cnt_o;
    logic [15:0] out_cnt_o;
    int          n_chk = 0, n_err = 0;

    always #5 clk_i = ~clk_i;

    hwpe_kernel_adapter_mc dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
        .in_max_i(in_max_i), .out_max_i(out_max_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .k_in_valid_o(k_in_valid_o), .k_in_ready_i(k_in_ready_i), .k_in_data_o(k_in_data_o),
        .k_out_valid_i(k_out_valid_i), .k_out_ready_o(k_out_ready_o), .k_out_data_i(k_out_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .ready_o(ready_o), .done_o(done_o), .idle_o(idle_o),
        .in_cnt_o(in_cnt_o), .out_cnt_o(out_cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_job(input logic [31:0] im, input logic [15:0] om);
        in_max_i  = im;
        out_max_i = om;
        start_i   = 1;
        tick();
        start_i   = 0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n = 0;
        while (!done_o && n < bound) begin
            tick();
            n++;
        end
        check(tag, done_o, 1);
    endtask

    initial begin
        int hs, rcv, pulses;
        rst_i = 1; clear_i = 0; start_i = 0; in_max_i = 0; out_max_i = 0;
        in_valid_i = 0; k_in_ready_i = 0; in_data_i = 0;
        k_out_valid_i = 0; out_ready_i = 0; k_out_data_i = 0;
        tick(); tick();
        rst_i = 0;
        in_valid_i = 2'b11; k_in_ready_i = 2'b11; k_out_valid_i = 1; out_ready_i = 1;
        #1;
        check("rst_idle", idle_o, 1);
        check("rst_ready", ready_o, 0);
        check("rst_done", done_o, 0);
        check("rst_cnt", {in_cnt_o, out_cnt_o}, 0);
        check("rst_gates", {k_in_valid_o, in_ready_o, out_valid_o, k_out_ready_o}, 0);
        in_valid_i = 0; k_in_ready_i = 0; k_out_valid_i = 0; out_ready_i = 0;

        // basic job: in {4,4}, out {2}
        start_job({16'd4, 16'd4}, 16'd2);
        check("basic_run", idle_o, 0);
        in_data_i = 64'h0123_4567_89ab_cdef;
        in_valid_i = 2'b11; k_in_ready_i = 2'b11;
        #1;
        check("basic_kin_data", k_in_data_o, 64'h0123_4567_89ab_cdef);
        check("basic_in_open", {k_in_valid_o, in_ready_o}, 4'b1111);
        repeat (4) tick();
        check("basic_in_closed", {k_in_valid_o, in_ready_o}, 0);
        check("basic_ready", ready_o, 1);
        check("basic_in_cnt", in_cnt_o, {16'd4, 16'd4});
        in_valid_i = 0;
        k_out_data_i = 32'hcafe_f00d; k_out_valid_i = 1; out_ready_i = 1;
        #1;
        check("basic_out_data", out_data_o, 32'hcafe_f00d);
        check("basic_out_open", {out_valid_o, k_out_ready_o}, 2'b11);
        repeat (2) tick();
        check("basic_out_cnt", out_cnt_o, 2);
        check("basic_out_closed", out_valid_o, 0);
        check("basic_done_t1", done_o, 0);
        k_out_valid_i = 0;
        tick();
        check("basic_done_t2", done_o, 1);
        check("basic_ready_fall", ready_o, 0);
        tick();
        check("basic_done_once", done_o, 0);
        check("basic_idle_t3", idle_o, 1);
        check("basic_cnt_hold", {in_cnt_o, out_cnt_o}, {16'd4, 16'd4, 16'd2});

        // over-feed gating: in {3,3}
        start_job({16'd3, 16'd3}, 16'd1);
        in_valid_i = 2'b11; k_in_ready_i = 2'b11; hs = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (in_ready_o[0] && in_valid_i[0]) hs++;
            tick();
        end
        check("over_hs", hs, 3);
        check("over_ready_low", in_ready_o, 0);
        check("over_cnt", in_cnt_o, {16'd3, 16'd3});
        in_valid_i = 0;
        k_out_valid_i = 1; out_ready_i = 1;
        tick();
        k_out_valid_i = 0;
        wait_done("over_done", 5);
        tick();

        // backpressure: out {5}, in limits 0 so ready is immediate
        start_job(32'd0, 16'd5);
        check("bp_ready_zero_in", ready_o, 1);
        rcv = 0; pulses = 0; k_out_valid_i = 1;
        for (int c = 0; c < 60; c++) begin
            out_ready_i = (c % 3 == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            k_out_data_i = 32'd100 + 32'(rcv);
            #1;
            if (done_o) pulses++;
            if (out_valid_o && out_ready_i) begin
                check("bp_data", out_data_o, 32'd100 + 32'(rcv));
                rcv++;
            end
            tick();
        end
        k_out_valid_i = 0; out_ready_i = 0;
        check("bp_rcv", rcv, 5);
        check("bp_cnt", out_cnt_o, 5);
        check("bp_pulses", pulses, 1);
        check("bp_idle", idle_o, 1);

        // zero output limits: done at t+2, no output handshakes
        start_job({16'd2, 16'd2}, 16'd0);
        k_out_valid_i = 1; out_ready_i = 1;
        #1;
        check("zero_gate", {out_valid_o, k_out_ready_o}, 0);
        check("zero_done_t1", done_o, 0);
        tick();
        check("zero_done_t2", done_o, 1);
        tick();
        check("zero_idle", idle_o, 1);
        check("zero_out_cnt", out_cnt_o, 0);
        k_out_valid_i = 0; out_ready_i = 0;

        // clear after 2 of 4 inputs
        start_job({16'd4, 16'd4}, 16'd1);
        in_valid_i = 2'b11; k_in_ready_i = 2'b11;
        repeat (2) tick();
        check("clr_mid_cnt", in_cnt_o, {16'd2, 16'd2});
        clear_i = 1;
        tick();
        clear_i = 0;
        check("clr_idle", idle_o, 1);
        check("clr_cnt", {in_cnt_o, out_cnt_o}, 0);
        check("clr_gates", in_ready_o, 0);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            if (done_o) pulses++;
            tick();
        end
        check("clr_no_done", pulses, 0);
        start_job({16'd4, 16'd4}, 16'd1);
        repeat (4) tick();
        check("clr_restart_ready", ready_o, 1);
        in_valid_i = 0;
        k_out_valid_i = 1; out_ready_i = 1;
        tick();
        k_out_valid_i = 0;
        check("clr_restart_t1", done_o, 0);
        tick();
        check("clr_restart_done", done_o, 1);
        tick();

        // simultaneous clear and start: clear wins
        clear_i = 1; start_i = 1;
        tick();
        clear_i = 0; start_i = 0;
        check("clr_start_idle", idle_o, 1);

        // ignored restart during RUN
        start_job(32'd0, 16'd3);
        k_out_valid_i = 1; out_ready_i = 1;
        tick();
        start_i = 1;
        tick();
        start_i = 0;
        check("rs_cnt_kept", out_cnt_o, 2);
        tick();
        k_out_valid_i = 0;
        check("rs_cnt_full", out_cnt_o, 3);
        check("rs_done_t1", done_o, 0);
        tick();
        check("rs_done_t2", done_o, 1);
        tick();
        check("rs_idle", idle_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/hwpe_kernel_adapter_mc.md
# hwpe_kernel_adapter_mc

This block is the multi-channel, parametrised successor of the single-kernel HWPE adapter. It sits between the HWPE streamer and the accelerated kernel. It forwards `N_IN` input streams and `N_OUT` output streams with zero latency and counts their handshakes against per-job limits programmed by the controller. From those counts it produces the `ready`, `done` and `idle` flags consumed by the engine FSM, and it gates each channel so the kernel never takes more than the programmed beats per job.

## Interface
Parameters:
- `N_IN`, 2: number of input (sink) channels, ≥1.
- `N_OUT`, 1: number of output (source) channels, ≥1.
- `DATA_W`, 32: data width per channel.
- `CNT_W`, 16: width of per-channel beat counters and limits.

Ports (one clock; reset is synchronous and active-high):
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous active-high reset.
- `clear_i`  in  1  synchronous soft clear; same effect as reset.
- `start_i`  in  1  job start pulse from controller.
- `in_max_i`  in  `N_IN*CNT_W`  beats expected per input channel per job.
- `out_max_i`  in  `N_OUT*CNT_W`  beats expected per output channel per job.
- `in_valid_i` / `in_ready_o`  in/out  `N_IN`  streamer-side input handshake.
- `in_data_i`  in  `N_IN*DATA_W`  streamer-side input data.
- `k_in_valid_o` / `k_in_ready_i`  out/in  `N_IN`  kernel-side input handshake.
- `k_in_data_o`  out  `N_IN*DATA_W`  kernel-side input data.
- `k_out_valid_i` / `k_out_ready_o`  in/out  `N_OUT`  kernel-side output handshake.
- `k_out_data_i`  in  `N_OUT*DATA_W`  kernel-side output data.
- `out_valid_o` / `out_ready_i`  out/in  `N_OUT`  streamer-side output handshake.
- `out_data_o`  out  `N_OUT*DATA_W`  streamer-side output data.
- `ready_o`  out  1  all input channels reached their limit.
- `done_o`  out  1  one-cycle job-complete pulse.
- `idle_o`  out  1  adapter idle.
- `in_cnt_o`  out  `N_IN*CNT_W`  live input counters.
- `out_cnt_o`  out  `N_OUT*CNT_W`  live output counters.

## Operation
- FSM states: IDLE, RUN, DONE. Reset and clear force IDLE.
- IDLE → RUN on `start_i`. All counters clear to 0 in the same edge. `in_max_i` and `out_max_i` are sampled into internal registers at that edge and held for the job.
- RUN → DONE when every output counter equals its registered limit. The evaluation uses the registered counters.
- DONE → IDLE unconditionally after one cycle.
- `start_i` in RUN or DONE is ignored.
- Channel i is *open* when the state is RUN and `in_cnt[i] < in_lim[i]`.
  - `k_in_valid_o[i] = in_valid_i[i] & open`.
  - `in_ready_o[i] = k_in_ready_i[i] & open`.
  - Data passes through unconditionally.
- Output channel j is gated the same way against `out_lim[j]`, using `k_out_ready_o` and `out_valid_o`.
- Counters increment by 1 on each gated handshake (valid & ready, both sides). Gating makes them saturate at their limit; they never wrap.
- A channel with a limit of 0 is satisfied immediately and never opens.
- `ready_o = (state == RUN) & all in_cnt[i] == in_lim[i]`.
- `done_o = (state == DONE)`.
- `idle_o = (state == IDLE)`.
- Counters hold their values in IDLE after a job until the next start, so they stay observable.
- Clear or reset mid-job:
  - All gates close in the same cycle the FSM returns to IDLE.
  - Counters go to 0.
  - No `done_o` pulse is produced.
- Simultaneous `clear_i` and `start_i`: clear wins and the state stays IDLE.

## Timing
- Reset values:
  - `idle_o` = 1.
  - `ready_o`, `done_o` = 0.
  - All counters = 0.
  - All valid/ready outputs = 0, except pass-through terms, which are 0 because the FSM is in IDLE.
- Data path: zero latency, purely combinational through the gates. There are no bubbles while a channel is open.
- `start_i` high at cycle t gives state RUN at t+1, and channels are open from t+1.
- The last output handshake at cycle t gives:
  - counter == limit at t+1 and `done_o` = 0 at t+1;
  - state DONE with `done_o` = 1 at t+2;
  - `idle_o` = 1 at t+3.
- If all `out_max` are 0: start at t, RUN at t+1, DONE at t+2.
- `ready_o` rises the cycle after the last input handshake and falls on leaving RUN.

## Test plan
- **Basic job:** N_IN=2, N_OUT=1, limits in={4,4}, out={2}. Start, then stream 4+4 inputs and 2 outputs. Expect `ready_o` after the 4th beat on both inputs, `done_o` high for exactly one cycle two cycles after the 2nd output, and `idle_o` back one cycle later.
- **Over-feed gating:** `in_valid_i` held high for 10 cycles with in limit {3}. Expect exactly 3 handshakes, `in_ready_o` = 0 afterwards, and `in_cnt_o` = 3.
- **Backpressure:** toggle `out_ready_i` randomly with out limit {5}. Expect no beat lost or duplicated, `out_cnt_o` = 5, and a single `done_o` pulse.
- **Zero limits:** out limits all 0. Start at t. Expect `done_o` at t+2 and no handshakes accepted.
- **Clear mid-job:** pulse `clear_i` after 2 of 4 inputs. Expect immediate IDLE, counters 0, no `done_o`, and a following start that runs normally.
- **Ignored restart:** `start_i` asserted during RUN. Expect no counter reset and `done_o` at the original time.
